mem_dma: RTL and testbench
==========================

Name: mem_dma

Overview:
- Word-granular DMA initiator for the data-memory port: drives a, din, mread, mwrite and consumes dout.
- Performs block copy (memmove semantics) or block fill inside the single-port, combinational-read / synchronous-write data memory.
- Used by test firmware and by boot-time memory initialisation.
- Sits between the control path and the data memory's address/data mux.

Parameters:
- S, 32, data word width (matches data memory).
- L, 256, memory depth in words; address width AW = $clog2(L).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill
- src  in  AW  source base word address (copy only)
- dst  in  AW  destination base word address
- len  in  AW+1  word count, 0..L
- fill_val  in  S  fill pattern (fill only)
- busy  out  1  high in RD and WR states
- done  out  1  one-cycle completion pulse
- count  out  AW+1  words written so far in current/last job
- a  out  AW  memory address
- din  out  S  memory write data
- dout  in  S  memory read data, combinational from a
- mread  out  1  read strobe
- mwrite  out  1  write strobe

Behaviour:
- Reset (synchronous, wins over everything, including mid-job):
  - state = IDLE.
  - busy, done, mread, mwrite = 0; a = 0; din = 0; count = 0.
  - A partially completed job is abandoned; words already written stay written.
- Outputs are Moore, decoded from state and registered job fields.
- In IDLE and DONE: a = 0, din = 0, mread = 0, mwrite = 0.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - On start = 1, latch mode, src, dst, len, fill_val; clear count.
  - len = 0: go to DONE (no memory access).
  - Else copy: go to RD; fill: go to WR.
- Direction (copy only), decided at start:
  - Descending if dst > src (unsigned): offsets run len-1 down to 0.
  - Otherwise ascending: offsets run 0 up to len-1.
  - Fill is always ascending.
- RD:
  - a = src + off (mod L), mread = 1.
  - dout is captured into a hold register at the clock edge.
  - Next state: WR.
- WR:
  - a = dst + off (mod L), mwrite = 1.
  - din = hold register (copy) or fill_val (fill).
  - count increments at the edge.
  - If count + 1 == len: go to DONE. Else step off, then go to RD (copy) or stay in WR (fill).
- DONE: done = 1 for exactly one cycle, then IDLE. count holds its final value until the next accepted start.
- Latency from the start edge to the done cycle:
  - copy: 2*len + 1 cycles.
  - fill: len + 1 cycles.
  - len = 0: 1 cycle.
- start while not in IDLE is ignored. start asserted in the DONE cycle is ignored; it must be held or reasserted in IDLE.
- Address arithmetic is AW-bit, wrapping modulo L.
- Overlap correctness (memmove semantics) is guaranteed only when neither range wraps past L-1.
- src == dst copy is legal: each word is rewritten with its own value.
- len = L: every location is touched once; count ends at L.

Test Plan:
1. Copy, non-overlapping: mem[10..13] = 11,22,33,44; start, mode=0, src=10, dst=100, len=4 -> mem[100..103] = 11,22,33,44; done asserted 9 cycles after the start edge; count = 4; source unchanged.
2. Overlapping forward copy: mem[20..23] = 1,2,3,4; src=20, dst=21, len=4 (descending) -> mem[21..24] = 1,2,3,4 and mem[20] = 1. Also src=21, dst=20, len=3 on 1,2,3,4 at 20..23 (ascending) -> mem[20..22] = 2,3,4.
3. Fill with wrap: mode=1, dst=254, len=4, fill_val=32'hDEADBEEF -> locations 254, 255, 0, 1 = DEADBEEF; mwrite high 4 consecutive cycles; done at cycle 5.
4. len = 0: start with len=0 -> done pulses on the next cycle; mread and mwrite never asserted; count = 0.
5. start during busy: pulse start with different src/dst mid-job of scenario 1 -> ignored; scenario 1 results unchanged; no second done.
6. Reset mid-op: assert reset in the 3rd WR cycle of a len=8 copy -> next cycle IDLE, all outputs 0; exactly 2 destination words are modified; a fresh start then completes normally.

Source files
------------

// File: rtl/mem_dma.sv
// Word-granular DMA initiator for the data-memory port: block copy with
// memmove ordering, or block fill, over a combinational-read / sync-write RAM.
module mem_dma #(
    parameter int S  = 32,
    parameter int L  = 256,
    localparam int AW = $clog2(L)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW:0]   len,
    input  logic [S-1:0]  fill_val,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   count,
    output logic [AW-1:0] a,
    output logic [S-1:0]  din,
    input  logic [S-1:0]  dout,
    output logic          mread,
    output logic          mwrite
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] OFF_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_r, state_nx_s;
    logic          mode_r, mode_nx_s;
    logic          desc_r, desc_nx_s;
    logic [AW-1:0] src_r, src_nx_s;
    logic [AW-1:0] dst_r, dst_nx_s;
    logic [AW-1:0] off_r, off_nx_s;
    logic [AW:0]   len_r, len_nx_s;
    logic [AW:0]   count_nx_s;
    logic [S-1:0]  fill_r, fill_nx_s;
    logic [S-1:0]  hold_r, hold_nx_s;

    logic          busy_nx_s, done_nx_s, mread_nx_s, mwrite_nx_s;
    logic [AW-1:0] a_nx_s;
    logic [S-1:0]  din_nx_s;

    // Next-state and job-field update
    always_comb begin
        state_nx_s = state_r;
        mode_nx_s  = mode_r;
        desc_nx_s  = desc_r;
        src_nx_s   = src_r;
        dst_nx_s   = dst_r;
        off_nx_s   = off_r;
        len_nx_s   = len_r;
        fill_nx_s  = fill_r;
        hold_nx_s  = hold_r;
        count_nx_s = count;
        case (state_r)
            IDLE: begin
                if (start) begin
                    mode_nx_s  = mode;
                    src_nx_s   = src;
                    dst_nx_s   = dst;
                    len_nx_s   = len;
                    fill_nx_s  = fill_val;
                    count_nx_s = {(AW+1){1'b0}};
                    // A copy whose destination lies above its source runs top-down
                    desc_nx_s  = (mode == 1'b0) && (dst > src);
                    if ((mode == 1'b0) && (dst > src)) begin
                        off_nx_s = len[AW-1:0] - OFF_ONE;
                    end else begin
                        off_nx_s = {AW{1'b0}};
                    end
                    if (len == {(AW+1){1'b0}}) begin
                        state_nx_s = DONE;
                    end else if (mode) begin
                        state_nx_s = WR;
                    end else begin
                        state_nx_s = RD;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RD: begin
                hold_nx_s  = dout;
                state_nx_s = WR;
            end
            WR: begin
                count_nx_s = count + CNT_ONE;
                if ((count + CNT_ONE) == len_r) begin
                    state_nx_s = DONE;
                end else begin
                    if (desc_r) begin
                        off_nx_s = off_r - OFF_ONE;
                    end else begin
                        off_nx_s = off_r + OFF_ONE;
                    end
                    if (mode_r) begin
                        state_nx_s = WR;
                    end else begin
                        state_nx_s = RD;
                    end
                end
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Moore output decode from the upcoming state so the ports come straight off flops
    always_comb begin
        busy_nx_s   = 1'b0;
        done_nx_s   = 1'b0;
        mread_nx_s  = 1'b0;
        mwrite_nx_s = 1'b0;
        a_nx_s      = {AW{1'b0}};
        din_nx_s    = {S{1'b0}};
        case (state_nx_s)
            RD: begin
                busy_nx_s  = 1'b1;
                mread_nx_s = 1'b1;
                a_nx_s     = src_nx_s + off_nx_s;
            end
            WR: begin
                busy_nx_s   = 1'b1;
                mwrite_nx_s = 1'b1;
                a_nx_s      = dst_nx_s + off_nx_s;
                if (mode_nx_s) begin
                    din_nx_s = fill_nx_s;
                end else begin
                    din_nx_s = hold_nx_s;
                end
            end
            DONE: begin
                done_nx_s = 1'b1;
            end
            IDLE: begin
                done_nx_s = 1'b0;
            end
            default: begin
                done_nx_s = 1'b0;
            end
        endcase
    end

    // State, job fields and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            mode_r  <= 1'b0;
            desc_r  <= 1'b0;
            src_r   <= {AW{1'b0}};
            dst_r   <= {AW{1'b0}};
            off_r   <= {AW{1'b0}};
            len_r   <= {(AW+1){1'b0}};
            fill_r  <= {S{1'b0}};
            hold_r  <= {S{1'b0}};
            count   <= {(AW+1){1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            mread   <= 1'b0;
            mwrite  <= 1'b0;
            a       <= {AW{1'b0}};
            din     <= {S{1'b0}};
        end else begin
            state_r <= state_nx_s;
            mode_r  <= mode_nx_s;
            desc_r  <= desc_nx_s;
            src_r   <= src_nx_s;
            dst_r   <= dst_nx_s;
            off_r   <= off_nx_s;
            len_r   <= len_nx_s;
            fill_r  <= fill_nx_s;
            hold_r  <= hold_nx_s;
            count   <= count_nx_s;
            busy    <= busy_nx_s;
            done    <= done_nx_s;
            mread   <= mread_nx_s;
            mwrite  <= mwrite_nx_s;
            a       <= a_nx_s;
            din     <= din_nx_s;
        end
    end

endmodule

// File: tb/tb_mem_dma.sv
// Scoreboard bench for mem_dma: expected writes and done events are queued by
// the stimulus, and a negedge monitor pops and compares them as they appear.
module tb_mem_dma;

    localparam int S  = 32;
    localparam int L  = 256;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] src = '0;
    logic [AW-1:0] dst = '0;
    logic [AW:0]   len = '0;
    logic [S-1:0]  fill_val = '0;
    logic          busy, done, mread, mwrite;
    logic [AW:0]   count;
    logic [AW-1:0] a;
    logic [S-1:0]  din;
    logic [S-1:0]  dout;

    logic [S-1:0]  mem [L];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [S-1:0]  data;
    } wr_t;
    typedef struct packed {
        logic [AW:0]  cnt;
        logic [31:0]  lat;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    mem_dma #(.S(S), .L(L)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .src(src), .dst(dst), .len(len), .fill_val(fill_val),
        .busy(busy), .done(done), .count(count),
        .a(a), .din(din), .dout(dout), .mread(mread), .mwrite(mwrite)
    );

    always #5 clk = ~clk;

    assign dout = mem[a];

    always @(posedge clk) begin
        if (mwrite) mem[a] <= din;
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: every write and every done pulse must match the next queued expectation
    always @(negedge clk) begin
        wr_t w;
        dn_t d;
        if (mread) rd_cnt++;
        if (mwrite) begin
            wr_cnt++;
            if (wq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: a=%0h din=%0h, no write expected", a, din);
            end else begin
                w = wq.pop_front();
                check("wr_addr", 64'(a), 64'(w.addr));
                check("wr_data", 64'(din), 64'(w.data));
            end
        end
        if (done) begin
            if (dq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: count=%0d, no done expected", count);
            end else begin
                d = dq.pop_front();
                check("done_count", 64'(count), 64'(d.cnt));
                check("done_latency", 64'(cyc - start_cyc + 1), 64'(d.lat));
            end
        end
    end

    task automatic push_wr(input int addr, input logic [S-1:0] data);
        wr_t w;
        w.addr = AW'(addr);
        w.data = data;
        wq.push_back(w);
    endtask

    task automatic push_done(input int cnt, input int lat);
        dn_t d;
        d.cnt = (AW+1)'(cnt);
        d.lat = 32'(lat);
        dq.push_back(d);
    endtask

    task automatic launch(input logic m, input int s, input int dd, input int n, input logic [S-1:0] f);
        @(negedge clk);
        mode = m; src = AW'(s); dst = AW'(dd); len = (AW+1)'(n); fill_val = f;
        start = 1'b1;
        rd_cnt = 0;
        wr_cnt = 0;
        @(posedge clk);
        #1 start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit got = 1'b0;
        if (done) got = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: no done within 100 cycles", name);
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        for (int i = 0; i < L; i++) mem[i] = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({busy, done, mread, mwrite, a, din, count}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Copy, non-overlapping (descending since dst > src), with a start pulse mid-job
        mem[10] = 32'd11; mem[11] = 32'd22; mem[12] = 32'd33; mem[13] = 32'd44;
        push_wr(103, 32'd44); push_wr(102, 32'd33); push_wr(101, 32'd22); push_wr(100, 32'd11);
        push_done(4, 9);
        launch(1'b0, 10, 100, 4, 32'd0);
        check("busy_in_job", 64'(busy), 64'd1);
        @(negedge clk);
        src = 8'd0; dst = 8'd200; len = 9'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("copy1");
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("copy1_dst", 64'(mem[100 + i]), 64'(11 * (i + 1)));
            check("copy1_src", 64'(mem[10 + i]), 64'(11 * (i + 1)));
        end
        check("ignored_dst200", 64'(mem[200]), 64'd0);
        check("copy1_rd_cnt", 64'(rd_cnt), 64'd4);

        // Overlapping copy upward: descending order preserves the source
        mem[20] = 32'd1; mem[21] = 32'd2; mem[22] = 32'd3; mem[23] = 32'd4; mem[24] = 32'd0;
        push_wr(24, 32'd4); push_wr(23, 32'd3); push_wr(22, 32'd2); push_wr(21, 32'd1);
        push_done(4, 9);
        launch(1'b0, 20, 21, 4, 32'd0);
        wait_done("ovl_up");
        check("ovl_up_20", 64'(mem[20]), 64'd1);
        for (int i = 0; i < 4; i++) check("ovl_up_dst", 64'(mem[21 + i]), 64'(i + 1));

        // Overlapping copy downward: ascending order
        mem[20] = 32'd1; mem[21] = 32'd2; mem[22] = 32'd3; mem[23] = 32'd4;
        push_wr(20, 32'd2); push_wr(21, 32'd3); push_wr(22, 32'd4);
        push_done(3, 7);
        launch(1'b0, 21, 20, 3, 32'd0);
        wait_done("ovl_dn");
        for (int i = 0; i < 3; i++) check("ovl_dn_dst", 64'(mem[20 + i]), 64'(i + 2));
        check("ovl_dn_23", 64'(mem[23]), 64'd4);

        // Fill wrapping past the top of memory
        push_wr(254, 32'hDEADBEEF); push_wr(255, 32'hDEADBEEF);
        push_wr(0, 32'hDEADBEEF);   push_wr(1, 32'hDEADBEEF);
        push_done(4, 5);
        launch(1'b1, 0, 254, 4, 32'hDEADBEEF);
        wait_done("fill");
        check("fill_wr_cnt", 64'(wr_cnt), 64'd4);
        check("fill_rd_cnt", 64'(rd_cnt), 64'd0);
        check("fill_254", 64'(mem[254]), 64'hDEADBEEF);
        check("fill_1", 64'(mem[1]), 64'hDEADBEEF);
        check("fill_2", 64'(mem[2]), 64'd0);

        // Zero-length job: done only, no memory traffic
        push_done(0, 1);
        launch(1'b0, 5, 6, 0, 32'd0);
        wait_done("len0");
        check("len0_rd_cnt", 64'(rd_cnt), 64'd0);
        check("len0_wr_cnt", 64'(wr_cnt), 64'd0);

        // Reset mid-copy: reset lands on the edge that would begin the third write
        for (int i = 0; i < 8; i++) mem[60 + i] = 32'(100 + i);
        push_wr(40, 32'd100); push_wr(41, 32'd101);
        launch(1'b0, 60, 40, 8, 32'd0);
        n = 0;
        if (mwrite) n++;
        for (int i = 0; i < 50 && n < 2; i++) begin
            @(negedge clk);
            if (mwrite) n++;
        end
        check("rst_two_writes_seen", 64'(n), 64'd2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midop_reset_outputs", 64'({busy, done, mread, mwrite, a, din, count}), 64'd0);
        check("rst_40", 64'(mem[40]), 64'd100);
        check("rst_41", 64'(mem[41]), 64'd101);
        check("rst_42", 64'(mem[42]), 64'd0);
        check("rst_47", 64'(mem[47]), 64'd0);

        // Fresh job after the abort completes normally
        for (int i = 0; i < 8; i++) push_wr(40 + i, 32'(100 + i));
        push_done(8, 17);
        launch(1'b0, 60, 40, 8, 32'd0);
        wait_done("after_rst");
        check("after_rst_47", 64'(mem[47]), 64'd107);
        check("after_rst_count_hold", 64'(count), 64'd8);

        repeat (5) @(negedge clk);
        check("wq_drained", 64'(wq.size()), 64'd0);
        check("dq_drained", 64'(dq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
